// File: rtl/alu_div_if.sv
// alu_div_if: request/response bundle between the execute stage and the divider.
interface alu_div_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_div_a;
    logic [WIDTH-1:0] i_div_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_div_result;
    modport master (output i_start, i_op, i_div_a, i_div_b, input o_busy, o_done, o_div_result);
    modport slave  (input i_start, i_op, i_div_a, i_div_b, output o_busy, o_done, o_div_result);
endinterface

// File: rtl/alu_div.sv
// alu_div: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, fixed WIDTH+1 cycle latency.
module alu_div #(parameter int WIDTH = 32) (
    input logic     i_clk,
    input logic     i_rst_n,
    alu_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state;
    logic             is_rem, neg_q, neg_r, div0, ovf;
    logic             sgn, a_neg, b_neg;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_raw, b_mag, rem, q, rem_nx, q_nx, fix, a_mag, b_in_mag;
    logic [WIDTH:0]   trial;
    always_comb begin
        sgn      = ~bus.i_op[0];
        a_neg    = sgn & bus.i_div_a[WIDTH-1];
        b_neg    = sgn & bus.i_div_b[WIDTH-1];
        a_mag    = a_neg ? -bus.i_div_a : bus.i_div_a;
        b_in_mag = b_neg ? -bus.i_div_b : bus.i_div_b;
        // Shifted remainder is WIDTH+1 bits so divisors above 2^(WIDTH-1) still work.
        trial    = {rem, q[WIDTH-1]} - {1'b0, b_mag};
        rem_nx   = trial[WIDTH] ? {rem[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
        q_nx     = {q[WIDTH-2:0], ~trial[WIDTH]};
        fix      = div0 ? (is_rem ? a_raw : '1) :
                   ovf  ? (is_rem ? '0 : MIN) :
                   is_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -q_nx : q_nx);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            bus.o_busy       <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_div_result <= '0;
            count            <= '0;
            rem              <= '0;
            q                <= '0;
            b_mag            <= '0;
            a_raw            <= '0;
            is_rem           <= 1'b0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
            div0             <= 1'b0;
            ovf              <= 1'b0;
        end else if (state != CALC && bus.i_start) begin
            state      <= CALC;
            bus.o_busy <= 1'b1;
            bus.o_done <= 1'b0;
            count      <= CW'(WIDTH);
            rem        <= '0;
            q          <= a_mag;
            b_mag      <= b_in_mag;
            a_raw      <= bus.i_div_a;
            is_rem     <= bus.i_op[1];
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            div0       <= bus.i_div_b == '0;
            ovf        <= sgn & (bus.i_div_a == MIN) & (bus.i_div_b == '1);
        end else if (state == CALC) begin
            rem   <= rem_nx;
            q     <= q_nx;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                state            <= DONE;
                bus.o_busy       <= 1'b0;
                bus.o_done       <= 1'b1;
                bus.o_div_result <= fix;
            end
        end else begin
            state      <= IDLE;
            bus.o_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: randomized and directed checks of alu_div against an arithmetic reference model.
module tb_alu_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    alu_div_if #(.WIDTH(32)) bus();
    alu_div #(.WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_div_a = a;
        bus.i_div_b = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check("busy_rise", {31'b0, bus.o_busy}, 32'd1);
    endtask
    task automatic finish_op(input string tag, input logic [31:0] exp, input int pulse_at = -1);
        int n = 0;
        bit busy_ok = 1'b1;
        while (!bus.o_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.o_done && !bus.o_busy) busy_ok = 1'b0;
            if (n == pulse_at) begin
                bus.i_start = 1'b1;
                bus.i_op    = 2'($urandom);
                bus.i_div_a = $urandom;
                bus.i_div_b = $urandom;
            end else bus.i_start = 1'b0;
        end
        check({tag, "_lat"}, n, 32);
        check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, "_res"}, bus.o_div_result, exp);
    endtask
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        finish_op(tag, ref_div(op, a, b));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'b0, bus.o_done}, 32'd0);
        check({tag, "_hold"}, bus.o_div_result, ref_div(op, a, b));
    endtask
    initial begin
        bit seen;
        logic [31:0] a, b;
        logic [1:0]  op;
        bus.i_start = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_div_a = '0;
        bus.i_div_b = '0;
        #12;
        check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
        check("rst_done", {31'b0, bus.o_done}, 32'd0);
        check("rst_res", bus.o_div_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("const_divu", ref_div(2'b01, 100, 7), 32'h0000_000E);
        run("divu", 2'b01, 100, 7);
        run("remu", 2'b11, 100, 7);
        run("div_neg", 2'b00, 32'hFFFF_FFF9, 2);
        run("rem_neg", 2'b10, 32'hFFFF_FFF9, 2);
        run("div_negb", 2'b00, 7, 32'hFFFF_FFFE);
        run("rem_negb", 2'b10, 7, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) run("div0", 2'(i), 32'h1234_5678, 0);
        for (int i = 0; i < 4; i++) run("ovf", 2'(i), 32'h8000_0000, 32'hFFFF_FFFF);
        run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("remu_big", 2'b11, 32'hFFFF_FFFD, 32'h8000_0001);
        start_op(2'b01, 1000, 7);
        finish_op("mid_start", 32'd142, 10);
        start_op(2'b01, 9, 3);
        finish_op("b2b", 32'd3);
        start_op(2'b01, 1000, 3);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.o_busy}, 32'd0);
        check("arst_done", {31'b0, bus.o_done}, 32'd0);
        check("arst_res", bus.o_div_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.o_done || bus.o_busy) seen = 1'b1;
        end
        check("arst_idle", {31'b0, seen}, 32'd0);
        @(negedge clk);
        run("post_rst", 2'b01, 50, 5);
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 300);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run("rand", op, a, b);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
